// File: rtl/rf_pkg.sv
// Shared definitions for the register-file dump reader: default geometry and FSM encoding.
package rf_pkg;

  localparam int N     = 32;
  localparam int R     = 32;
  localparam int ASIZE = $clog2(R);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    SEND,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/rfdump_xor_acc.sv
// N-bit XOR accumulator with synchronous clear and enable; feeds the optional checksum beat.
module rfdump_xor_acc #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= q ^ d;
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register index range through the register file's registered read port and streams
// (index, data) beats on valid/ready. Define RFDUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dump_reader #(
  parameter int N     = rf_pkg::N,
  parameter int R     = rf_pkg::R,
  parameter int ASIZE = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ASIZE-1:0] first_id,
  input  logic [ASIZE-1:0] last_id,
  output logic [ASIZE-1:0] rd_id,
  input  logic [N-1:0]     rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ASIZE-1:0] out_id,
  output logic [N-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  import rf_pkg::*;

  state_t           state, state_nxt;
  logic [ASIZE-1:0] idx, last_q, idx_inc;
  logic             hs, at_last;

  assign hs      = out_valid && out_ready;
  assign at_last = (idx == last_q);
  assign idx_inc = (idx == ASIZE'(R - 1)) ? '0 : idx + 1'b1;

  // The index register doubles as the read address, so it naturally holds outside ADDR.
  assign rd_id = idx;

`ifdef RFDUMP_CHECKSUM_EN
  localparam state_t AFTER_LAST = CSUM;
  logic [N-1:0] acc_q;

  rfdump_xor_acc #(.N(N)) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE && start),
    .en  (state == WAIT),
    .d   (rd_data),
    .q   (acc_q)
  );
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADDR;
      ADDR:    state_nxt = WAIT;
      WAIT:    state_nxt = SEND;
      SEND:    if (hs) state_nxt = at_last ? AFTER_LAST : ADDR;
      CSUM:    if (hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == SEND) || (state == CSUM);
    busy      = (state == ADDR) || (state == WAIT) || (state == SEND) || (state == CSUM);
    done      = (state == DONE);
`ifdef RFDUMP_CHECKSUM_EN
    out_last  = (state == CSUM);
`else
    out_last  = (state == SEND) && at_last;
`endif
  end

  // Beat payload is captured once in WAIT and held through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      last_q   <= '0;
      out_id   <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx    <= first_id;
          last_q <= last_id;
        end
        WAIT: begin
          out_id   <= idx;
          out_data <= rd_data;
        end
        SEND: if (hs) begin
          if (!at_last) idx <= idx_inc;
`ifdef RFDUMP_CHECKSUM_EN
          else begin
            out_id   <= '0;
            out_data <= acc_q;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader against a reg[i] = 3*i register-file model.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_id, last_id, rd_id, out_id;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_ready, out_last, busy, done;

  logic [31:0] regs [32];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         beats;
    int         done_cyc;
  } vec_t;

  vec_t vecs [5];

  regfile_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_id  (first_id),
    .last_id   (last_id),
    .rd_id     (rd_id),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Registered read port with one cycle of latency.
  always @(posedge clk) rd_data <= regs[rd_id];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    first_id = f;
    last_id  = l;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, done, 1);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rd_id"},     rd_id, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_id"},    out_id, 0);
    check({name, "_out_data"},  out_data, 0);
    check({name, "_out_last"},  out_last, 0);
    check({name, "_busy"},      busy, 0);
    check({name, "_done"},      done, 0);
  endtask

  // Runs one dump with out_ready held high; cycle 1 is the cycle after the start edge.
  task automatic run_dump(input vec_t v);
    logic [4:0]  id = v.first;
    logic [31:0] x = 0;
    int          nb = 0;
    int          exp_beats = v.beats;
    int          exp_done = v.done_cyc;
    bit          got_done = 0;
`ifdef RFDUMP_CHECKSUM_EN
    exp_beats++;
    exp_done++;
`endif
    out_ready = 1'b1;
    pulse_start(v.first, v.last);
    check("busy_after_start", busy, 1);
    for (int c = 1; c <= 200 && !got_done; c++) begin
      if (out_valid && out_ready) begin
        if (nb < v.beats) begin
          check("beat_id", out_id, id);
          check("beat_data", out_data, 3 * id);
          x ^= 32'(3 * id);
`ifdef RFDUMP_CHECKSUM_EN
          check("beat_last", out_last, 0);
`else
          check("beat_last", out_last, nb == v.beats - 1);
`endif
          id = (id == 5'd31) ? 5'd0 : id + 5'd1;
        end else begin
          check("csum_id", out_id, 0);
          check("csum_data", out_data, x);
          check("csum_last", out_last, 1);
        end
        nb++;
      end
      if (done) begin
        got_done = 1;
        check("done_cycle", c, exp_done);
        check("beat_count", nb, exp_beats);
        check("busy_in_done", busy, 0);
      end else begin
        @(negedge clk);
      end
    end
    if (!got_done) check("dump_timeout", 0, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    bit seen;

    for (int i = 0; i < 32; i++) regs[i] = 32'(3 * i);
    vecs[0] = '{first: 5'd0,  last: 5'd31, beats: 32, done_cyc: 97};
    vecs[1] = '{first: 5'd30, last: 5'd1,  beats: 4,  done_cyc: 13};
    vecs[2] = '{first: 5'd5,  last: 5'd5,  beats: 1,  done_cyc: 4};
    vecs[3] = '{first: 5'd31, last: 5'd0,  beats: 2,  done_cyc: 7};
    vecs[4] = '{first: 5'd1,  last: 5'd3,  beats: 3,  done_cyc: 10};

    rst = 1'b1; start = 1'b0; first_id = '0; last_id = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_dump(vecs[i]);

    // Backpressure on the id-4 beat with a register write during the stall.
    out_ready = 1'b0;
    pulse_start(5'd4, 5'd5);
    wait_valid("bp_first", 10);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_id", out_id, 4);
      check("bp_data", out_data, 12);
      check("bp_last", out_last, 0);
      if (i == 1) regs[4] = 32'd999;
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp_release_data", out_data, 12);
    @(negedge clk);
    wait_valid("bp_second", 10);
    check("bp_next_id", out_id, 5);
    check("bp_next_data", out_data, 15);
`ifndef RFDUMP_CHECKSUM_EN
    check("bp_next_last", out_last, 1);
`endif
    wait_done("bp", 20);
    regs[4] = 32'd12;

    // Single register, with a second start issued while busy.
    pulse_start(5'd7, 5'd7);
    first_id = 5'd20; last_id = 5'd21; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("single", 10);
    check("single_id", out_id, 7);
    check("single_data", out_data, 21);
`ifdef RFDUMP_CHECKSUM_EN
    check("single_last", out_last, 0);
`else
    check("single_last", out_last, 1);
`endif
    wait_done("single", 10);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid || busy) seen = 1;
      @(negedge clk);
    end
    check("single_ignored_start", seen, 0);

    // Reset in the middle of a dump at the id-10 beat.
    pulse_start(5'd8, 5'd12);
    for (int i = 0; i < 40 && !(out_valid && out_id == 5'd10); i++) @(negedge clk);
    check("mid_reached_id10", out_id, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("mid_reset");
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || out_valid) seen = 1;
      @(negedge clk);
    end
    check("mid_no_done", seen, 0);
    run_dump('{first: 5'd8, last: 5'd12, beats: 5, done_cyc: 16});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the 32×32 register file. On a start pulse it walks a register index range through one registered read port of the register file, captures each word and streams it out as (index, data) beats on a valid/ready interface. It sits beside the register file: it owns the read-address port, and the debug/trace logic consumes the stream. It replaces the simulation-only periodic `$display` dump with a synthesizable path.

## Interface
- `N`, 32, data width per register
- `R`, 32, number of registers
- `ASIZE`, `$clog2(R)`, register index width
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  single-cycle request to begin a dump
- `first_id`  in  ASIZE  first index; latched on an accepted `start`
- `last_id`  in  ASIZE  last index, inclusive; latched on an accepted `start`
- `rd_id`  out  ASIZE  register file read address; drives `reg_id_r1`
- `rd_data`  in  N  register file read data, from `data_out1`
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  consumer ready
- `out_id`  out  ASIZE  index of the current beat
- `out_data`  out  N  data of the current beat
- `out_last`  out  1  marks the final beat of the dump
- `busy`  out  1  high from the accepted `start` until the final beat is accepted
- `done`  out  1  one-cycle pulse after the final beat handshake

## Operation
- States and transitions:
  - IDLE: `start` → ADDR; latch `first_id` and `last_id`; set `idx = first_id`.
  - ADDR: drive `rd_id = idx` → WAIT.
  - WAIT: `rd_data` is valid this cycle; capture it into `out_data`, set `out_id = idx` → SEND.
  - SEND: `out_valid = 1`. On `out_valid && out_ready`:
    - if `idx == last_id` → DONE;
    - otherwise `idx = (idx + 1) mod R` → ADDR.
  - DONE: `done = 1` for one cycle → IDLE.
- Wrap-around:
  - If `last_id < first_id`, the walk goes `first_id … R-1, 0 … last_id`.
  - If `first_id == last_id`, exactly one beat is produced.
  - Beat count is `((last_id - first_id) mod R) + 1`.
- `out_last` is high in SEND only when `idx == last_id`, or on the checksum beat when that feature is compiled in.
- Backpressure: while `out_ready` is low, `out_valid`, `out_id`, `out_data` and `out_last` hold stable. The captured word does not change even if the register file is written meanwhile.
- `start` is ignored while `busy` is high.
- `rd_id` holds its last value outside ADDR.

## Timing
- Reset: on any rising edge with `rst = 1`, the state goes to IDLE and all outputs go to 0: `rd_id`, `out_valid`, `out_id`, `out_data`, `out_last`, `busy`, `done`. This includes mid-dump; the partial dump is abandoned with no `done`.
- `start` sampled at edge k → `busy` high and state ADDR from cycle k+1.
- Register read latency is 1 clock. The address is presented in ADDR, data arrives in WAIT, and `out_valid` rises in the following cycle.
- Minimum of 3 cycles per beat when `out_ready` is held high.
- A full 32-register dump with `out_ready = 1` takes 96 cycles from the start edge to the last handshake, then 1 cycle of `done`.
- `busy` falls in the DONE cycle.

## Configuration
- `RFDUMP_CHECKSUM_EN` defined:
  - XOR-accumulate every captured word (accumulator cleared on an accepted `start`).
  - After the `last_id` beat, emit one extra beat with `out_id = 0`, `out_data` = XOR of all words, `out_last = 1`, then go to DONE.
  - On the `last_id` data beat itself, `out_last = 0`.
- `RFDUMP_CHECKSUM_EN` undefined: no accumulator and no extra beat; `out_last` sits on the `last_id` beat.

## Structure
- Shared package `rf_pkg`: `N`, `R`, `ASIZE` defaults, and the state encoding constants (IDLE, ADDR, WAIT, SEND, CSUM, DONE).
- One sub-module, `rfdump_xor_acc`: N-bit XOR accumulator with clear and enable. It is instantiated only under `RFDUMP_CHECKSUM_EN`.

## Test plan
- Register file preloaded with reg[i] = 3·i.
  - `first_id = 0`, `last_id = 31`, `out_ready = 1` → 32 beats (i, 3·i); `out_last` only on id 31; `done` at cycle 97 after start.
- Wrap: `first_id = 30`, `last_id = 1` → beats ids 30, 31, 0, 1 with data 90, 93, 0, 3; then `done`.
- Backpressure: `out_ready` low for 5 cycles on the id-4 beat, and reg[4] is written to 999 during the stall → beat stays (4, 12) and stable; the next beat is (5, 15).
- Single register: `first_id = last_id = 7` → exactly one beat (7, 21) with `out_last = 1`. A second `start` while busy is ignored.
- Reset mid-dump: `rst` high for 1 cycle at the id-10 beat → next cycle all outputs are 0, state is IDLE, no `done`. A new `start` restarts cleanly from `first_id`.
- With `RFDUMP_CHECKSUM_EN`, ids 1..3 (data 3, 6, 9) → 3 data beats, then checksum beat `out_data = 3^6^9 = 12`, `out_last = 1`.
